mux_bus_arbiter: RTL and testbench
==================================

Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares the processor's 8-bit, 4-input bus multiplexer between four requesters (ALU result, register file, memory read port, immediate/IO).
- Owns the mux's 2-bit select, issues a one-hot grant to the winning requester and holds that grant until the owner releases.
- Inserts one turnaround cycle between owners.
- Optionally forces release after a bounded hold time.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per ownership when ARB_TIMEOUT_EN is defined; legal range 2..255; ignored otherwise.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req  input  4  request lines; bit i = requester i (i maps to mux input in1..in4 as sel = i)
- gnt  output  4  registered one-hot grant; all-zero when bus idle
- sel  output  2  registered mux select; index of current or most recent owner
- bus_busy  output  1  registered; 1 while any gnt bit set
- grant_pulse  output  1  registered; 1 for exactly the first cycle of each new grant
- timeout_pulse  output  1  registered; 1 for one cycle when an ownership is forcibly ended; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - gnt=0000, sel=2'b00, bus_busy=0, grant_pulse=0, timeout_pulse=0.
  - State IDLE, priority pointer ptr=2'd3 (requester 0 highest after reset), hold counter=0.
- States:
  - IDLE: no owner.
  - GRANT: one owner.
- IDLE, at each rising edge:
  - If req != 0: pick the winner by searching ptr+1, ptr+2, ptr+3, ptr (mod 4, wrap-around).
  - Registered outputs after that edge: gnt=onehot(winner), sel=winner, bus_busy=1, grant_pulse=1.
  - ptr<=winner; hold counter<=0; go to GRANT.
  - Latency: req high before edge k gives gnt visible after edge k (1 cycle).
- GRANT, at each rising edge:
  - Owner releases (req[owner]=0) → IDLE. gnt=0000 and bus_busy=0 for at least one cycle (turnaround). sel keeps the old owner.
  - Otherwise hold: gnt and sel unchanged, grant_pulse=0, hold counter +1 (saturating at 255).
- Requests from non-owners while in GRANT are ignored: no preemption, no queueing state. A requester must keep req high until granted.
- Fairness:
  - ptr records the last owner, so the owner that just released has lowest priority at the next arbitration.
  - Each continuously requesting requester is granted within 3 other ownerships.
- Simultaneous events:
  - Owner drops req in the same cycle others raise req: release takes effect first, and the new winner is granted one cycle later (after the turnaround IDLE cycle).
  - A non-owner raising req exactly at release is eligible at that IDLE cycle.
- Mid-operation reset: any state collapses immediately to the reset values, including ptr. No pulse outputs are asserted during or immediately after reset.
- gnt is never multi-hot. sel only changes on a grant edge. grant_pulse is never high while gnt=0000.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when the hold counter equals MAX_HOLD-1 and req[owner] is still 1, the next edge forces release.
  - Release means gnt=0000, bus_busy=0, timeout_pulse=1 for one cycle, state IDLE; ptr remains the owner.
  - The owner may re-request but is lowest priority. If it is the only requester it is re-granted after the single turnaround cycle.
  - Total GRANT cycles per ownership never exceed MAX_HOLD.
- Not defined: the timeout comparator is absent, ownership is unbounded, and timeout_pulse is tied 0.

Test Plan:
- Reset then req=0001: after 1 edge gnt=0001, sel=00, grant_pulse=1 for one cycle, bus_busy=1. Drop req: next cycle gnt=0000, sel stays 00.
- req=1111 held, each owner releases after 3 cycles then immediately re-requests: grant order 0,1,2,3,0. Each ownership is separated by exactly one gnt=0000 cycle.
- Owner 2 granted, req[0] and req[3] rise during ownership: no gnt change until req[2] falls. Then order is 3 before 0 (search from ptr=2).
- Assert rst while gnt=0100, mid-cycle asynchronously: gnt=0000, sel=00, pulses 0 immediately. After release with req=1001, requester 0 wins.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req=0010 held: gnt=0010 for exactly 4 cycles, then 1 cycle gnt=0000 with timeout_pulse=1, then re-grant to 1 with grant_pulse=1.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011 held: owner 0 times out after 4 cycles. Requester 1 is then granted ahead of 0, and timeout_pulse is never multi-cycle.

Source files
------------

// File: rtl/mux_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mux_bus_arbiter
//   Round-robin owner of the processor's 8-bit, 4-input bus multiplexer.
//   Requesters: 0 = ALU result, 1 = register file, 2 = memory read port,
//   3 = immediate/IO (requester i drives mux input sel = i).
//
//   A winner keeps the bus until it drops its request. Every ownership is
//   followed by one idle turnaround cycle (gnt = 0000) before the next grant.
//   The last owner is remembered in ptr and has lowest priority at the next
//   arbitration.
//
//   Optional feature (macro ARB_TIMEOUT_EN): an ownership is forcibly ended
//   after MAX_HOLD consecutive grant cycles. The ended owner may request
//   again but arbitrates at lowest priority. Without the macro the timeout
//   comparator is absent and timeout_pulse is tied low.
//
// Parameters
//   MAX_HOLD      : max grant cycles per ownership with ARB_TIMEOUT_EN (2..255)
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   req[3:0]      : request lines, bit i = requester i
//   gnt[3:0]      : registered one-hot grant, 0000 when idle
//   sel[1:0]      : registered mux select, current or most recent owner
//   bus_busy      : registered, high while any gnt bit is set
//   grant_pulse   : registered, high on the first cycle of each new grant
//   timeout_pulse : registered, high for one cycle when an ownership is
//                   forcibly ended
// -----------------------------------------------------------------------------

// One grant flop per requester; the arbiter core decides the next value.
module mux_bus_arbiter_lane (
    input  logic clk,
    input  logic rst,
    input  logic gnt_nxt,
    output logic gnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gnt <= 1'b0;
        else     gnt <= gnt_nxt;
    end
endmodule

module mux_bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_busy,
    output logic       grant_pulse,
    output logic       timeout_pulse
);
    localparam int NUM_REQ = 4;

    // Out-of-range hold limits are rejected at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_bus_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [1:0]         sel_nxt;
    logic [7:0]         hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               busy_nxt;
    logic               gp_nxt;
    logic               win_found;
    logic [1:0]         winner;
    logic               owner_req;
    logic               timeout_hit;
    logic               release_now;

    // In GRANT, sel is the owner's index.
    assign owner_req   = req[sel];
    assign release_now = (state == GRANT) && (!owner_req || timeout_hit);

    // Round-robin search ptr+1, ptr+2, ptr+3, ptr: the last owner is tried
    // last. The 2-bit add wraps naturally, so k = 4 lands back on ptr.
    always_comb begin
        win_found = 1'b0;
        winner    = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [1:0] cand;
            cand = ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // hold_cnt is 0 on the first grant cycle, so reaching MAX_HOLD-1 means
    // this is the MAX_HOLD-th grant cycle and the next edge must release.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    assign timeout_hit = (state == GRANT) && owner_req && (hold_cnt == HOLD_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found)   state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        ptr_nxt  = ptr;
        sel_nxt  = sel;
        hold_nxt = hold_cnt;
        gnt_nxt  = gnt;
        busy_nxt = bus_busy;
        gp_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    ptr_nxt  = winner;
                    sel_nxt  = winner;
                    hold_nxt = 8'd0;
                    gnt_nxt  = NUM_REQ'(1) << winner;
                    busy_nxt = 1'b1;
                    gp_nxt   = 1'b1;
                end else begin
                    gnt_nxt  = '0;
                    busy_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // sel and ptr keep the old owner through the turnaround.
                    gnt_nxt  = '0;
                    busy_nxt = 1'b0;
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            sel         <= 2'd0;
            hold_cnt    <= 8'd0;
            bus_busy    <= 1'b0;
            grant_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            sel         <= sel_nxt;
            hold_cnt    <= hold_nxt;
            bus_busy    <= busy_nxt;
            grant_pulse <= gp_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_pulse <= 1'b0;
        else     timeout_pulse <= timeout_hit;
    end
`else
    assign timeout_pulse = 1'b0;
`endif

    // Per-requester grant flops.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        mux_bus_arbiter_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .gnt_nxt (gnt_nxt[i]),
            .gnt     (gnt[i])
        );
    end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
module tb_mux_bus_arbiter;
    localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_busy, grant_pulse, timeout_pulse;

    int checks = 0;
    int errors = 0;

    mux_bus_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .gnt           (gnt),
        .sel           (sel),
        .bus_busy      (bus_busy),
        .grant_pulse   (grant_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // owner = -1 when the bus is idle; last = requester with lowest priority;
    // held = number of grant cycles already spent by the current owner.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_gp    = 0;
    bit m_tp    = 0;

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_sel = 0; m_held = 0; m_gp = 0; m_tp = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        m_gp = 0;
        m_tp = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c; m_last = c; m_sel = c; m_held = 1; m_gp = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_held == MAXH) begin
            m_owner = -1;
            m_tp    = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_gnt",  int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
        chk("model_sel",  int'(sel), m_sel);
        chk("model_busy", int'(bus_busy), (m_owner < 0) ? 0 : 1);
        chk("model_gp",   int'(grant_pulse), int'(m_gp));
        chk("model_tp",   int'(timeout_pulse), int'(m_tp));
        chk("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        chk("gp_needs_gnt", (grant_pulse && gnt == 4'b0000) ? 1 : 0, 0);
    endtask

    // Drive req at the falling edge, let one rising edge happen, sample 1ns later.
    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_model();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       gp;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [3:0] r;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  int'(gnt), 0);
        chk("rst_sel",  int'(sel), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_gp",   int'(grant_pulse), 0);
        chk("rst_tp",   int'(timeout_pulse), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table from reset (ptr starts at 3).
        tbl[0] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[1] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{4'b1100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[5] = '{4'b1001, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[6] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[7] = '{4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[8] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[9] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].req);
            chk($sformatf("tbl%0d_gnt", i),  int'(gnt), int'(tbl[i].gnt));
            chk($sformatf("tbl%0d_sel", i),  int'(sel), int'(tbl[i].sel));
            chk($sformatf("tbl%0d_busy", i), int'(bus_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_gp", i),   int'(grant_pulse), int'(tbl[i].gp));
        end

        // Round robin with all four requesting; each owner holds 3 cycles.
        reset_dut();
        for (int o = 0; o < 5; o++) begin
            step(4'b1111);
            chk("rr_order", int'(sel), o % 4);
            chk("rr_gp", int'(grant_pulse), 1);
            step(4'b1111);
            step(4'b1111);
            chk("rr_hold", int'(gnt), 1 << (o % 4));
            r = 4'b1111;
            r[o % 4] = 1'b0;
            step(r);
            chk("rr_turnaround", int'(gnt), 0);
        end

        // No preemption; after release, search from ptr=2 favours 3 over 0.
        reset_dut();
        step(4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(4'b1101);
            chk("nopre_gnt", int'(gnt), 4'b0100);
        end
        step(4'b1001);
        chk("nopre_release", int'(gnt), 0);
        chk("nopre_sel_kept", int'(sel), 2);
        step(4'b1001);
        chk("nopre_next3", int'(sel), 3);
        step(4'b0001);
        step(4'b0001);
        chk("nopre_then0", int'(gnt), 4'b0001);

        // Asynchronous reset in the middle of a grant.
        reset_dut();
        step(4'b0100);
        chk("arst_pre", int'(gnt), 4'b0100);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("arst_gnt",  int'(gnt), 0);
        chk("arst_sel",  int'(sel), 0);
        chk("arst_busy", int'(bus_busy), 0);
        chk("arst_gp",   int'(grant_pulse), 0);
        chk("arst_tp",   int'(timeout_pulse), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1001);
        chk("arst_ptr_reset", int'(gnt), 4'b0001);

        // Randomized traffic against the model; owners usually keep requesting.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            step(r);
        end

        step(4'b0000);
        step(4'b0000);
`ifdef ARB_TIMEOUT_EN
        // Single requester: MAX_HOLD grant cycles, timeout, turnaround, re-grant.
        for (int i = 0; i < MAXH; i++) begin
            step(4'b0010);
            chk("to1_gnt", int'(gnt), 4'b0010);
            chk("to1_gp", int'(grant_pulse), (i == 0) ? 1 : 0);
        end
        step(4'b0010);
        chk("to1_release", int'(gnt), 0);
        chk("to1_tp", int'(timeout_pulse), 1);
        step(4'b0010);
        chk("to1_regrant", int'(gnt), 4'b0010);
        chk("to1_regrant_gp", int'(grant_pulse), 1);
        chk("to1_tp_single", int'(timeout_pulse), 0);

        // Two requesters: timed-out owner 0 yields to 1.
        step(4'b0000);
        step(4'b0000);
        for (int i = 0; i < MAXH; i++) begin
            step(4'b0011);
            chk("to2_gnt", int'(gnt), 4'b0001);
        end
        step(4'b0011);
        chk("to2_tp", int'(timeout_pulse), 1);
        chk("to2_release", int'(gnt), 0);
        step(4'b0011);
        chk("to2_next1", int'(gnt), 4'b0010);
        chk("to2_tp_single", int'(timeout_pulse), 0);
`else
        // Without the timeout, a long hold never ends and never pulses.
        for (int i = 0; i < 20; i++) begin
            step(4'b0010);
            chk("notimeout_gnt", int'(gnt), 4'b0010);
            chk("notimeout_tp", int'(timeout_pulse), 0);
        end
`endif
        step(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
